// File: rtl/gmii_rx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_rx_ctrl_pkg
//  Description : Shared speed encodings, FSM state type and divider helpers
//                for the GMII receive-side control block.
//  Revision    : 1.0 - initial release
// ============================================================================
package gmii_rx_ctrl_pkg;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    // Terminal counts of the clock-enable divider (counts 0..N).
    localparam logic [6:0] c_DIV_MAX_10  = 7'd99;
    localparam logic [6:0] c_DIV_MAX_100 = 7'd9;

    typedef enum logic [1:0] {
        ST_STABLE  = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } state_t;

    // The reserved code 11 behaves exactly like gigabit, so fold it early.
    function automatic logic [1:0] norm_speed(input logic [1:0] speed);
        return (speed == 2'b11) ? SPEED_1000 : speed;
    endfunction

    function automatic logic [6:0] div_max(input logic [1:0] speed);
        case (speed)
            SPEED_10:  return c_DIV_MAX_10;
            SPEED_100: return c_DIV_MAX_100;
            default:   return 7'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/gmii_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_rx_ctrl_if
//  Description : Bundle of receiver monitor, configuration and statistics
//                signals between the GMII receiver and its control block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gmii_rx_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    // Receiver activity, monitored only
    logic                 gmii_rx_dv;
    logic                 rx_tvalid;
    logic                 rx_tlast;
    logic                 rx_tuser;
    logic                 start_packet;
    logic                 error_bad_frame;
    logic                 error_bad_fcs;
    // Configuration request
    logic [1:0]           cfg_speed_req;
    logic                 cfg_rx_enable_req;
    logic                 cfg_apply;
    logic                 stat_clear;
    // Configuration in effect
    logic                 cfg_busy;
    logic [1:0]           cfg_speed;
    logic                 clk_enable;
    logic                 mii_select;
    logic                 cfg_rx_enable;
    // Statistics
    logic [CNT_WIDTH-1:0] stat_frames;
    logic [CNT_WIDTH-1:0] stat_bad_frame;
    logic [CNT_WIDTH-1:0] stat_bad_fcs;

    modport master (
        output gmii_rx_dv, rx_tvalid, rx_tlast, rx_tuser, start_packet,
               error_bad_frame, error_bad_fcs, cfg_speed_req,
               cfg_rx_enable_req, cfg_apply, stat_clear,
        input  cfg_busy, cfg_speed, clk_enable, mii_select, cfg_rx_enable,
               stat_frames, stat_bad_frame, stat_bad_fcs
    );

    modport slave (
        input  gmii_rx_dv, rx_tvalid, rx_tlast, rx_tuser, start_packet,
               error_bad_frame, error_bad_fcs, cfg_speed_req,
               cfg_rx_enable_req, cfg_apply, stat_clear,
        output cfg_busy, cfg_speed, clk_enable, mii_select, cfg_rx_enable,
               stat_frames, stat_bad_frame, stat_bad_fcs
    );

endinterface
`default_nettype wire

// File: rtl/gmii_rx_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating event counter with synchronous clear. A clear
//                that coincides with an event leaves the count at one.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc,
    input  wire logic             clr,
    output logic [WIDTH-1:0]      count
);

    localparam logic [WIDTH-1:0] c_MAX = '1;
    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // Clear wins over saturation; an event in the clear cycle is still counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= inc ? c_ONE : '0;
        end else if (inc && (r_count != c_MAX)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/gmii_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_rx_ctrl
//  Description : Applies speed / receive-enable changes to a GMII receiver
//                only at a frame boundary after a quiet idle gap, generates
//                the MII clock enable and keeps receive statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module gmii_rx_ctrl
    import gmii_rx_ctrl_pkg::*;
#(
    parameter int IDLE_GAP  = 12,
    parameter int CNT_WIDTH = 32
) (
    input wire logic       clk,
    input wire logic       rst,
    gmii_rx_ctrl_if.slave  bus
);

    localparam int                  c_IDLE_W   = (IDLE_GAP < 1) ? 1 : $clog2(IDLE_GAP + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(IDLE_GAP);
    localparam logic [c_IDLE_W-1:0] c_IDLE_ONE = c_IDLE_W'(1);

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_latch;
    logic                  w_apply;
    logic [1:0]            r_req_speed;
    logic                  r_req_en;
    logic [1:0]            r_speed;
    logic                  r_rx_en;
    logic                  r_mii_sel;
    logic                  r_busy;
    logic                  r_frame_active;
    logic [c_IDLE_W-1:0]   r_idle_cnt;
    logic [6:0]            r_div;
    logic [6:0]            w_div_max;
    logic [6:0]            w_div_next;
    logic                  r_clk_en;
    logic                  w_last;
    logic [CNT_WIDTH-1:0]  w_stat_frames;
    logic [CNT_WIDTH-1:0]  w_stat_bad_frame;
    logic [CNT_WIDTH-1:0]  w_stat_bad_fcs;
    logic                  w_unused_tuser;

    assign w_last         = bus.rx_tvalid && bus.rx_tlast;
    assign w_unused_tuser = bus.rx_tuser;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_STABLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus the latch / apply strobes that drive the config registers.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_apply      = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (bus.cfg_apply) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // A newer request overwrites the old one; the idle wait carries on.
                w_latch = bus.cfg_apply;
                if (!r_frame_active && (r_idle_cnt == c_IDLE_MAX)) begin
                    w_state_next = ST_APPLY;
                end
            end
            ST_APPLY: begin
                w_apply      = 1'b1;
                w_state_next = ST_STABLE;
            end
            default: begin
                w_state_next = ST_STABLE;
            end
        endcase
    end

    // Latched request, configuration in effect and the busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_speed <= SPEED_1000;
            r_req_en    <= 1'b0;
            r_speed     <= SPEED_1000;
            r_rx_en     <= 1'b0;
            r_mii_sel   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_latch) begin
                r_req_speed <= norm_speed(bus.cfg_speed_req);
                r_req_en    <= bus.cfg_rx_enable_req;
            end
            if (w_apply) begin
                r_speed   <= r_req_speed;
                r_rx_en   <= r_req_en;
                r_mii_sel <= (r_req_speed == SPEED_10) || (r_req_speed == SPEED_100);
                r_busy    <= 1'b0;
            end else if (w_latch) begin
                r_busy    <= 1'b1;
            end
        end
    end

    // Divider wrap point for the speed currently in effect.
    always_comb begin
        w_div_max  = div_max(r_speed);
        w_div_next = (r_div >= w_div_max) ? 7'd0 : (r_div + 7'd1);
    end

    // Divider and clock enable; the enable is registered alongside the divider
    // so it is high exactly in the cycles where the divider reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div    <= 7'd0;
            r_clk_en <= 1'b1;
        end else if (w_apply) begin
            r_div    <= 7'd0;
            r_clk_en <= 1'b1;
        end else begin
            r_div    <= w_div_next;
            r_clk_en <= (w_div_next == 7'd0);
        end
    end

    // Frame boundary tracking; a start in the same cycle as a tlast wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_active <= 1'b0;
        end else if (bus.start_packet) begin
            r_frame_active <= 1'b1;
        end else if (w_last) begin
            r_frame_active <= 1'b0;
        end
    end

    // Idle gap measured in enabled line cycles, saturating at the gap length.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (bus.gmii_rx_dv) begin
            r_idle_cnt <= '0;
        end else if (r_clk_en && (r_idle_cnt != c_IDLE_MAX)) begin
            r_idle_cnt <= r_idle_cnt + c_IDLE_ONE;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_frames (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_last),
        .clr   (bus.stat_clear),
        .count (w_stat_frames)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_bad_frame (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.error_bad_frame),
        .clr   (bus.stat_clear),
        .count (w_stat_bad_frame)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_bad_fcs (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.error_bad_fcs),
        .clr   (bus.stat_clear),
        .count (w_stat_bad_fcs)
    );

    assign bus.cfg_busy       = r_busy;
    assign bus.cfg_speed      = r_speed;
    assign bus.clk_enable     = r_clk_en;
    assign bus.mii_select     = r_mii_sel;
    assign bus.cfg_rx_enable  = r_rx_en;
    assign bus.stat_frames    = w_stat_frames;
    assign bus.stat_bad_frame = w_stat_bad_frame;
    assign bus.stat_bad_fcs   = w_stat_bad_fcs;

endmodule
`default_nettype wire

// File: tb/tb_gmii_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gmii_rx_ctrl
//  Description : Directed and randomized checks of gmii_rx_ctrl against a
//                cycle-level behavioural model of the control rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gmii_rx_ctrl;

    localparam int GAP  = 6;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    gmii_rx_ctrl_if #(.CNT_WIDTH(CW)) bus ();

    gmii_rx_ctrl #(.IDLE_GAP(GAP), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural model: speeds as 0=10M, 1=100M, 2=1000M; the clock enable
    // is derived from the number of cycles elapsed since the last change.
    int m_frames, m_bad_frame, m_bad_fcs, m_idle, m_since, m_speed, m_req_speed;
    bit m_fa, m_pending, m_applying, m_busy, m_en, m_req_en;

    function automatic int sat_next(input int v, input bit inc, input bit clr);
        if (clr) return inc ? 1 : 0;
        if (inc) return (v < CMAX) ? v + 1 : CMAX;
        return v;
    endfunction

    function automatic bit m_clken();
        if (m_speed == 2) return 1'b1;
        return (m_since % ((m_speed == 0) ? 100 : 10)) == 0;
    endfunction

    task automatic model_update();
        bit ce, last, go;
        if (rst) begin
            m_frames = 0; m_bad_frame = 0; m_bad_fcs = 0; m_idle = 0; m_since = 0;
            m_speed = 2; m_req_speed = 2; m_fa = 0; m_pending = 0; m_applying = 0;
            m_busy = 0; m_en = 0; m_req_en = 0;
        end else begin
            ce   = m_clken();
            last = bus.rx_tvalid && bus.rx_tlast;
            go   = m_pending && !m_fa && (m_idle == GAP);
            m_frames    = sat_next(m_frames, last, bus.stat_clear);
            m_bad_frame = sat_next(m_bad_frame, bus.error_bad_frame, bus.stat_clear);
            m_bad_fcs   = sat_next(m_bad_fcs, bus.error_bad_fcs, bus.stat_clear);
            if (m_applying) begin
                m_speed = m_req_speed; m_en = m_req_en; m_since = 0;
                m_busy = 0; m_applying = 0;
            end else begin
                m_since++;
                if (bus.cfg_apply) begin
                    m_req_speed = (bus.cfg_speed_req == 2'b11) ? 2 : int'(bus.cfg_speed_req);
                    m_req_en    = bus.cfg_rx_enable_req;
                end
                if (m_pending) begin
                    if (go) begin m_pending = 0; m_applying = 1; end
                end else if (bus.cfg_apply) begin
                    m_pending = 1; m_busy = 1;
                end
            end
            m_fa = bus.start_packet ? 1'b1 : (last ? 1'b0 : m_fa);
            if (bus.gmii_rx_dv) m_idle = 0;
            else if (ce && (m_idle < GAP)) m_idle++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("cfg_busy",       32'(bus.cfg_busy),       32'(m_busy));
        chk("cfg_speed",      32'(bus.cfg_speed),      32'(m_speed));
        chk("cfg_rx_enable",  32'(bus.cfg_rx_enable),  32'(m_en));
        chk("clk_enable",     32'(bus.clk_enable),     32'(m_clken()));
        chk("mii_select",     32'(bus.mii_select),     32'(m_speed != 2));
        chk("stat_frames",    32'(bus.stat_frames),    32'(m_frames));
        chk("stat_bad_frame", 32'(bus.stat_bad_frame), 32'(m_bad_frame));
        chk("stat_bad_fcs",   32'(bus.stat_bad_fcs),   32'(m_bad_fcs));
    endtask

    // One clock: model follows the inputs the DUT sampled, outputs checked 1ns later.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic clear_pulses();
        bus.cfg_apply = 1'b0; bus.start_packet = 1'b0; bus.rx_tvalid = 1'b0;
        bus.rx_tlast = 1'b0; bus.rx_tuser = 1'b0; bus.error_bad_frame = 1'b0;
        bus.error_bad_fcs = 1'b0; bus.stat_clear = 1'b0;
    endtask

    task automatic apply(input logic [1:0] speed, input logic en);
        bus.cfg_speed_req = speed; bus.cfg_rx_enable_req = en; bus.cfg_apply = 1'b1;
        tick();
        bus.cfg_apply = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (bus.cfg_busy && (cyc < budget)) begin tick(); cyc++; end
        chk(tag, 32'(bus.cfg_busy), 32'(0));
    endtask

    initial begin
        int  cyc, cnt, falls;
        bit  saw00, prev;
        bus.gmii_rx_dv = 1'b0; bus.cfg_speed_req = 2'b00; bus.cfg_rx_enable_req = 1'b0;
        clear_pulses();
        rst = 1'b1;
        tick(); tick();
        chk("rst_speed_1000", 32'(bus.cfg_speed), 32'(2));
        chk("rst_clk_enable", 32'(bus.clk_enable), 32'(1));
        chk("rst_mii_select", 32'(bus.mii_select), 32'(0));
        chk("rst_busy",       32'(bus.cfg_busy), 32'(0));
        rst = 1'b0;

        // 100M enable while idle: applies quickly, enable pulses every 10 cycles
        repeat (GAP + 2) tick();
        apply(2'b01, 1'b1);
        chk("apply_sets_busy", 32'(bus.cfg_busy), 32'(1));
        wait_idle("apply_within_gap", GAP + 1, cyc);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin cnt += int'(bus.clk_enable); tick(); end
        chk("ce_100m_per_30", 32'(cnt), 32'(3));
        chk("mii_select_100m", 32'(bus.mii_select), 32'(1));

        // Disable requested mid-frame: held until tlast plus the idle gap
        bus.gmii_rx_dv = 1'b1; bus.start_packet = 1'b1; tick(); bus.start_packet = 1'b0;
        repeat (3) tick();
        apply(2'b01, 1'b0);
        repeat ($urandom_range(20, 40)) begin
            tick();
            chk("en_held_in_frame", 32'(bus.cfg_rx_enable), 32'(1));
        end
        bus.rx_tvalid = 1'b1; bus.rx_tlast = 1'b1; tick();
        bus.rx_tvalid = 1'b0; bus.rx_tlast = 1'b0; bus.gmii_rx_dv = 1'b0;
        chk("en_held_at_tlast", 32'(bus.cfg_rx_enable), 32'(1));
        wait_idle("disable_applied", (GAP + 3) * 10, cyc);
        chk("en_low_after_gap", 32'(bus.cfg_rx_enable), 32'(0));
        chk("gap_honoured", 32'(cyc >= (GAP - 1) * 10), 32'(1));

        // Two requests while pending: only the newest applies, once
        bus.gmii_rx_dv = 1'b1;
        apply(2'b00, 1'b1);
        repeat (5) tick();
        apply(2'b10, 1'b1);
        repeat (3) tick();
        chk("still_pending", 32'(bus.cfg_busy), 32'(1));
        bus.gmii_rx_dv = 1'b0;
        saw00 = 1'b0; falls = 0; prev = bus.cfg_busy;
        for (int i = 0; i < (GAP + 3) * 10; i++) begin
            tick();
            if (bus.cfg_speed == 2'b00) saw00 = 1'b1;
            if (prev && !bus.cfg_busy) falls++;
            prev = bus.cfg_busy;
        end
        chk("speed00_never_applied", 32'(saw00), 32'(0));
        chk("exactly_one_apply", 32'(falls), 32'(1));
        chk("newest_speed_1000", 32'(bus.cfg_speed), 32'(2));

        // 10M: one enable per 100 cycles; gaps counted in enabled cycles
        apply(2'b00, 1'b1);
        wait_idle("apply_10m", GAP + 3, cyc);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin cnt += int'(bus.clk_enable); tick(); end
        chk("ce_10m_per_100", 32'(cnt), 32'(1));
        bus.gmii_rx_dv = 1'b1;
        apply(2'b01, 1'b1);
        for (int k = 0; k < 3; k++) begin
            bus.gmii_rx_dv = 1'b0; repeat ((GAP - 1) * 100) tick();
            bus.gmii_rx_dv = 1'b1; tick();
        end
        chk("short_gap_blocks", 32'(bus.cfg_busy), 32'(1));
        bus.gmii_rx_dv = 1'b0;
        repeat (GAP * 10) tick();
        chk("raw_cycles_not_gap", 32'(bus.cfg_busy), 32'(1));
        wait_idle("long_gap_applies", (GAP + 2) * 100, cyc);
        chk("speed_100m_after", 32'(bus.cfg_speed), 32'(1));

        // Saturation and clear-with-increment
        bus.rx_tvalid = 1'b1; bus.rx_tlast = 1'b1; bus.error_bad_frame = 1'b1;
        repeat (CMAX + 5) tick();
        chk("frames_saturate", 32'(bus.stat_frames), 32'(CMAX));
        chk("bad_frame_saturate", 32'(bus.stat_bad_frame), 32'(CMAX));
        bus.error_bad_frame = 1'b0; bus.stat_clear = 1'b1; tick();
        chk("clear_with_tlast", 32'(bus.stat_frames), 32'(1));
        chk("clear_bad_frame", 32'(bus.stat_bad_frame), 32'(0));
        clear_pulses(); bus.stat_clear = 1'b1; tick(); bus.stat_clear = 1'b0;
        chk("clear_alone", 32'(bus.stat_frames), 32'(0));

        // Randomized traffic and configuration
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) bus.gmii_rx_dv = ~bus.gmii_rx_dv;
            bus.start_packet      = ($urandom_range(0, 29) == 0);
            bus.rx_tvalid         = 1'($urandom_range(0, 1));
            bus.rx_tlast          = ($urandom_range(0, 14) == 0);
            bus.rx_tuser          = 1'($urandom_range(0, 1));
            bus.error_bad_frame   = ($urandom_range(0, 9) == 0);
            bus.error_bad_fcs     = ($urandom_range(0, 9) == 0);
            bus.stat_clear        = ($urandom_range(0, 299) == 0);
            bus.cfg_apply         = ($urandom_range(0, 149) == 0);
            bus.cfg_speed_req     = 2'($urandom_range(0, 3));
            bus.cfg_rx_enable_req = 1'($urandom_range(0, 1));
            tick();
        end
        clear_pulses();

        // Reset while pending discards the request
        rst = 1'b1; tick(); rst = 1'b0;
        bus.gmii_rx_dv = 1'b1;
        apply(2'b01, 1'b1);
        chk("pending_before_rst", 32'(bus.cfg_busy), 32'(1));
        rst = 1'b1; bus.cfg_apply = 1'b1; bus.stat_clear = 1'b1; tick();
        rst = 1'b0; clear_pulses();
        chk("rst_drops_busy", 32'(bus.cfg_busy), 32'(0));
        chk("rst_keeps_1000", 32'(bus.cfg_speed), 32'(2));
        bus.gmii_rx_dv = 1'b0;
        repeat (GAP * 10 + 20) tick();
        chk("never_applied_busy", 32'(bus.cfg_busy), 32'(0));
        chk("never_applied_speed", 32'(bus.cfg_speed), 32'(2));
        chk("never_applied_en", 32'(bus.cfg_rx_enable), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gmii_rx_ctrl.md
GMII_RX_CTRL -- requirements
Module: gmii_rx_ctrl

Interface
REQ-001 SHALL have parameter IDLE_GAP, default 12, meaning the number of consecutive enabled idle cycles (gmii_rx_dv low) required before configuration changes apply.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, meaning the width of each statistics counter.
REQ-003 SHALL have port clk, input, 1, receive clock; reset is rst, synchronous, active-high; clock is clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port gmii_rx_dv, input, 1, raw receive data valid, monitored for idle detection.
REQ-006 SHALL have ports rx_tvalid, rx_tlast, rx_tuser, each input, 1, the receiver AXI output, monitored only.
REQ-007 SHALL have ports start_packet, error_bad_frame and error_bad_fcs, each input, 1, the receiver status pulses.
REQ-008 SHALL have port cfg_speed_req, input, 2, where 00 = 10M, 01 = 100M, 10 = 1000M and 11 is reserved and treated as 1000M.
REQ-009 SHALL have port cfg_rx_enable_req, input, 1, the requested receive enable.
REQ-010 SHALL have port cfg_apply, input, 1, a single-cycle pulse that latches both request fields.
REQ-011 SHALL have port cfg_busy, output, 1, high while a latched request has not yet taken effect.
REQ-012 SHALL have port cfg_speed, output, 2, the speed in effect.
REQ-013 SHALL have ports clk_enable, mii_select and cfg_rx_enable, each output, 1, driving the receiver.
REQ-014 SHALL have ports stat_frames, stat_bad_frame and stat_bad_fcs, each output, CNT_WIDTH, saturating counters.
REQ-015 SHALL have port stat_clear, input, 1, a pulse that zeroes all counters.

Function
REQ-016 SHALL implement states STABLE, PENDING and APPLY.
REQ-017 SHALL, in STABLE, on cfg_apply, latch the requests, set cfg_busy and enter PENDING.
REQ-018 SHALL track frame_active: set on start_packet; cleared on rx_tvalid&&rx_tlast; if both occur in the same cycle, frame_active ends set.
REQ-019 SHALL maintain the idle counter as follows: increment on cycles with clk_enable high and gmii_rx_dv low, saturating at IDLE_GAP; clear whenever gmii_rx_dv is high.
REQ-020 SHALL, in PENDING, enter APPLY when frame_active is low and the idle counter equals IDLE_GAP.
REQ-021 SHALL, in PENDING, overwrite the latched requests with the newest values on a further cfg_apply, without restarting the wait.
REQ-022 SHALL, in APPLY (one cycle), load cfg_speed and cfg_rx_enable, zero the divider, clear cfg_busy on the next cycle and return to STABLE.
REQ-023 SHALL, when disabling (cfg_rx_enable_req=0), still wait for the frame boundary so that no frame is truncated.
REQ-024 SHALL generate clk_enable as follows: constant 1 at 1000M; at 100M, high when the divider = 0 with the divider counting 0..9; at 10M, the same with the divider counting 0..99; the divider wraps to 0.
REQ-025 SHALL, on the first cycle after APPLY, have the divider at 0 and clk_enable high.
REQ-026 SHALL drive mii_select = 1 when cfg_speed is 00 or 01, and 0 otherwise; it is registered and changes only in APPLY.
REQ-027 SHALL update counters: stat_frames +1 on rx_tvalid&&rx_tlast; stat_bad_frame +1 on error_bad_frame; stat_bad_fcs +1 on error_bad_fcs; each saturates at all-ones.
REQ-028 SHALL, on stat_clear coincident with an increment, leave the counter at 1; stat_clear has priority over saturation.
REQ-029 SHALL make all outputs registered, with a latency of one cycle from the causing event.

Reset
REQ-030 SHALL set the following on rst: state STABLE, cfg_speed=10 (1000M), cfg_rx_enable=0, clk_enable=1, mii_select=0, cfg_busy=0, frame_active=0, idle counter 0, divider 0, all statistics counters 0.
REQ-031 SHALL, on rst during PENDING, discard the pending request.
REQ-032 SHALL give rst priority over cfg_apply and stat_clear in the same cycle.

Structure
REQ-033 SHALL place the speed encoding constants (SPEED_10, SPEED_100, SPEED_1000) and the state encodings in the shared eth package.
REQ-034 SHALL implement the counters as one sub-module, sat_counter (width parameter; inc and clr inputs), instantiated three times.
REQ-035 SHALL keep the divider and the state machine inline.

Verification
REQ-036 SHALL verify that after reset, cfg_apply with speed=01 and enable=1 while idle results in cfg_busy high, APPLY reached within IDLE_GAP+2 cycles, and clk_enable then pulsing exactly once per 10 cycles with mii_select=1.
REQ-037 SHALL verify that cfg_apply with enable=0 asserted mid-frame (start_packet already seen) holds cfg_rx_enable at 1 until tlast, then IDLE_GAP idle cycles, and only then drives it to 0.
REQ-038 SHALL verify that two cfg_apply pulses in PENDING (speed 00, then 10) result in only speed 10 being applied and exactly one APPLY.
REQ-039 SHALL verify that 10M mode produces exactly 1 clk_enable pulse in 100 cycles, that gmii_rx_dv toggling with a gap of fewer than IDLE_GAP enabled cycles blocks APPLY, and that the idle count is measured in enabled cycles.
REQ-040 SHALL verify that a counter preloaded near all-ones saturates at all-ones after further increments, and that stat_clear coincident with tlast yields stat_frames=1.
REQ-041 SHALL verify that rst asserted in PENDING returns cfg_busy=0, keeps the prior speed at 1000M, and never applies the pending request.
